// File: rtl/operand_fifo.sv
// operand_fifo: circular operand buffer with a registered read port,
// occupancy status, a saturating read counter and sticky overflow/underflow flags.
module operand_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    fifo_reset,
    input  logic                    fifo_writeEnable,
    input  logic [WIDTH-1:0]        wdata,
    input  logic                    fifo_readEnable,
    output logic [WIDTH-1:0]        rdata,
    output logic                    rvalid,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic [3:0]              acc_count,
    output logic                    ovf,
    output logic                    udf
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             rd_acc, wr_acc;
    // A read frees a slot in the same cycle, so a full FIFO can still take a write alongside it.
    always_comb begin
        full   = count == (AW+1)'(DEPTH);
        empty  = count == '0;
        rd_acc = fifo_readEnable && !empty;
        wr_acc = fifo_writeEnable && (!full || rd_acc);
    end
    always_ff @(posedge clock)
        if (wr_acc && !fifo_reset) mem[wr_ptr] <= wdata;
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            acc_count <= '0;
            rdata     <= '0;
            rvalid    <= 1'b0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
        end else if (fifo_reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            acc_count <= '0;
            rvalid    <= 1'b0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
        end else begin
            rvalid <= rd_acc;
            count  <= count + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) begin
                rdata  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (rd_acc && acc_count != 4'd8) acc_count <= acc_count + 4'd1;
            if (fifo_writeEnable && full && !rd_acc) ovf <= 1'b1;
            if (fifo_readEnable && empty) udf <= 1'b1;
        end
endmodule

// File: tb/tb_operand_fifo.sv
// tb_operand_fifo: table vectors, corner-case sequences and randomized traffic
// checked against a queue-based model of the operand FIFO.
module tb_operand_fifo;
    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clock = 1'b0, reset = 1'b0, fifo_reset = 1'b0;
    logic             fifo_writeEnable = 1'b0, fifo_readEnable = 1'b0;
    logic [WIDTH-1:0] wdata = '0, rdata;
    logic             rvalid, full, empty, ovf, udf;
    logic [CW-1:0]    count;
    logic [3:0]       acc_count;
    int               errors = 0, checks = 0;

    operand_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .fifo_reset(fifo_reset),
        .fifo_writeEnable(fifo_writeEnable), .wdata(wdata),
        .fifo_readEnable(fifo_readEnable), .rdata(rdata), .rvalid(rvalid),
        .full(full), .empty(empty), .count(count), .acc_count(acc_count),
        .ovf(ovf), .udf(udf)
    );

    always #5 clock = ~clock;

    // Reference model: contents as a queue plus the visible registers.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_rdata = '0;
    bit               m_rvalid, m_ovf, m_udf;
    int               m_acc;

    typedef struct {
        bit          we, re, fr;
        logic [31:0] wd;
        int          cnt;
        bit          rv;
        logic [31:0] rd;
        bit          fu, em;
        int          acc;
        bit          ov, ud;
    } vec_t;
    vec_t        v[19];
    logic [31:0] ops[8] = '{32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h40400000,
                            32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int cnt, input bit rv, input logic [31:0] rd,
                           input bit fu, input bit em, input int acc, input bit ov, input bit ud);
        chk({tag, " count"}, 32'(count), 32'(cnt));
        chk({tag, " rvalid"}, 32'(rvalid), 32'(rv));
        chk({tag, " rdata"}, rdata, rd);
        chk({tag, " full"}, 32'(full), 32'(fu));
        chk({tag, " empty"}, 32'(empty), 32'(em));
        chk({tag, " acc_count"}, 32'(acc_count), 32'(acc));
        chk({tag, " ovf"}, 32'(ovf), 32'(ov));
        chk({tag, " udf"}, 32'(udf), 32'(ud));
    endtask

    task automatic check_model(input string tag);
        chk_all(tag, q.size(), m_rvalid, m_rdata, q.size() == DEPTH, q.size() == 0,
                m_acc, m_ovf, m_udf);
    endtask

    task automatic model_reset();
        q.delete();
        m_rdata = '0; m_rvalid = 0; m_acc = 0; m_ovf = 0; m_udf = 0;
    endtask

    task automatic model_step(input bit we, input bit re, input bit fr, input logic [WIDTH-1:0] wd);
        int n = q.size();
        bit racc, wacc;
        if (fr) begin
            q.delete();
            m_rvalid = 0; m_acc = 0; m_ovf = 0; m_udf = 0;
            return;
        end
        racc = re && n > 0;
        wacc = we && (n < DEPTH || racc);
        if (re && n == 0) m_udf = 1;
        if (we && n == DEPTH && !racc) m_ovf = 1;
        m_rvalid = racc;
        if (racc) begin
            m_rdata = q.pop_front();
            if (m_acc < 8) m_acc++;
        end
        if (wacc) q.push_back(wd);
    endtask

    task automatic cycle(input bit we, input bit re, input bit fr, input logic [WIDTH-1:0] wd);
        fifo_writeEnable = we; fifo_readEnable = re; fifo_reset = fr; wdata = wd;
        @(posedge clock);
        model_step(we, re, fr, wd);
        #1;
        fifo_writeEnable = 0; fifo_readEnable = 0; fifo_reset = 0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++)
            v[i] = '{1, 0, 0, ops[i], i + 1, 0, 0, i == 7, 0, 0, 0, 0};
        v[8] = '{1, 0, 0, 32'hDEADBEEF, 8, 0, 0, 1, 0, 0, 1, 0};
        for (int k = 0; k < 8; k++)
            v[9+k] = '{0, 1, 0, 0, 7 - k, 1, ops[k], 0, k == 7, k + 1, 1, 0};
        v[17] = '{0, 1, 0, 0, 0, 0, ops[7], 0, 1, 8, 1, 1};
        v[18] = '{1, 1, 0, 32'h12345678, 1, 0, ops[7], 0, 0, 8, 1, 1};

        model_reset();
        repeat (2) @(posedge clock);
        #1 chk_all("reset", 0, 0, 0, 0, 1, 0, 0, 0);
        reset = 1'b1;

        for (int i = 0; i < 19; i++) begin
            cycle(v[i].we, v[i].re, v[i].fr, v[i].wd);
            chk_all($sformatf("vec%0d", i), v[i].cnt, v[i].rv, v[i].rd, v[i].fu, v[i].em,
                    v[i].acc, v[i].ov, v[i].ud);
        end

        // Full FIFO with simultaneous read+write: pointers wrap, order kept.
        for (int i = 0; i < 7; i++) cycle(1, 0, 0, $urandom);
        check_model("fill");
        for (int i = 0; i < 10; i++) begin
            cycle(1, 1, 0, $urandom);
            check_model($sformatf("rw_full%0d", i));
        end

        // Synchronous clear overrides same-cycle read and write.
        cycle(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 32'h100 + 32'(i));
        cycle(0, 1, 0, 0);
        cycle(1, 0, 0, 32'h200);
        check_model("pre_clear");
        cycle(1, 1, 1, 32'hCAFEF00D);
        chk_all("clear", 0, 0, m_rdata, 0, 1, 0, 0, 0);
        check_model("clear_model");

        // Asynchronous reset between edges at count=3.
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 32'h300 + 32'(i));
        check_model("pre_async");
        #2 reset = 1'b0;
        #1 model_reset();
        chk_all("async", 0, 0, 0, 0, 1, 0, 0, 0);
        #3 reset = 1'b1;
        cycle(1, 0, 0, 32'hABCD);
        check_model("post_async");

        // Randomized traffic, first filling-biased then draining-biased.
        for (int i = 0; i < 400; i++) begin
            bit we, re, fr;
            we = $urandom_range(0, 99) < (i < 200 ? 70 : 30);
            re = $urandom_range(0, 99) < (i < 200 ? 35 : 70);
            fr = $urandom_range(0, 63) == 0;
            cycle(we, re, fr, $urandom);
            check_model($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/operand_fifo.md
OPERAND_FIFO -- requirements
Module: operand_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (IEEE-754 single).
REQ-002 SHALL have parameter DEPTH, default 8, entry count, power of two, at least 2.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port fifo_reset  input  1  synchronous clear, active-high.
REQ-006 SHALL have port fifo_writeEnable  input  1  write request.
REQ-007 SHALL have port wdata  input  WIDTH  write operand (memory read data).
REQ-008 SHALL have port fifo_readEnable  input  1  read request.
REQ-009 SHALL have port rdata  output  WIDTH  registered read operand.
REQ-010 SHALL have port rvalid  output  1  rdata valid this cycle.
REQ-011 SHALL have port full  output  1  occupancy equals DEPTH.
REQ-012 SHALL have port empty  output  1  occupancy equals 0.
REQ-013 SHALL have port count  output  log2(DEPTH)+1  current occupancy.
REQ-014 SHALL have port acc_count  output  4  accepted reads since clear, saturating.
REQ-015 SHALL have port ovf  output  1  sticky: write attempted while full, no read.
REQ-016 SHALL have port udf  output  1  sticky: read attempted while empty.

Function
REQ-017 SHALL store entries in a circular buffer with write and read pointers, each log2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-018 SHALL accept a write when fifo_writeEnable=1 and (full=0 or an accepted read occurs the same cycle).
REQ-019 SHALL accept a read when fifo_readEnable=1 and empty=0.
REQ-020 SHALL on an accepted write store wdata at write pointer and advance it by one.
REQ-021 SHALL on an accepted read register the entry at read pointer into rdata on the same edge, advance the read pointer, and assert rvalid for exactly the next cycle (1-cycle latency).
REQ-022 SHALL hold rdata at last value when no read is accepted; rvalid=0 in that cycle.
REQ-023 SHALL on simultaneous accepted read and write keep count unchanged; on full both occur; on empty only the write occurs and udf sets.
REQ-024 SHALL derive full, empty from count combinationally from registered state; never both 1.
REQ-025 SHALL increment acc_count on every accepted read, saturating at 4'd8; further reads leave it at 8.
REQ-026 SHALL set ovf on write request with full=1 and no accepted read; data and pointers unchanged.
REQ-027 SHALL set udf on read request with empty=1; pointers, rdata unchanged, rvalid=0.
REQ-028 SHALL on fifo_reset=1 clear pointers, count, acc_count, ovf, udf, rvalid; rdata holds; fifo_reset overrides any same-cycle read or write.
REQ-029 SHALL not require storage contents to be cleared by any reset.

Reset
REQ-030 SHALL while reset=0 asynchronously force pointers=0, count=0, acc_count=0, rdata=0, rvalid=0, ovf=0, udf=0, giving empty=1, full=0.
REQ-031 SHALL resume normal operation on the first rising clock edge after reset deasserts; reset mid-operation discards all contents.

Verification
REQ-032 Write 8 operands 0x3F800000..0x40E00000 with reads idle -> full=1 after 8th edge, count=8; 9th write -> ovf=1, contents unchanged.
REQ-033 Read 8 from full FIFO -> rdata in write order, rvalid one cycle after each request, acc_count 1..8, empty=1 after last.
REQ-034 Read on empty FIFO -> udf=1, rvalid=0, acc_count unchanged; simultaneous read+write on empty -> count=1, no rvalid.
REQ-035 Simultaneous read+write while full for 10 cycles -> count stays 8, pointers wrap, FIFO order preserved, acc_count saturates at 8.
REQ-036 Assert fifo_reset with write and read requested at count=5 -> next cycle count=0, empty=1, acc_count=0, ovf=udf=0, rvalid=0.
REQ-037 Drop reset mid-fill at count=3 between clock edges -> outputs immediately at reset values; after release, first write gives count=1.
